// File: rtl/cpu_sequencer.sv
// Clocked multi-cycle sequencer for the 8-bit CPU: one state per clock, one enable
// per datapath phase, data-memory wait states with timeout, and a halt stop state.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_op,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             reg_w_en,
    input  logic             mem_ready,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             regrd_en,
    output logic             exec_en,
    output logic             mem_req,
    output logic             wbsel_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic             busy,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_REGRD  = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WBSEL  = 4'd5,
        S_WB     = 4'd6,
        S_PCUPD  = 4'd7,
        S_IDLE   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_timeout;

    // mem_ready wins over an expiring wait count
    assign mem_timeout = !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
            retired  <= '0;
        end else begin
            wait_cnt <= (state_q == S_MEM) ? wait_cnt + 1'b1 : '0;
            if (state_q == S_MEM && mem_timeout) begin
                mem_err <= 1'b1;
            end
            if (state_q == S_PCUPD) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = halt_op ? S_HALT : S_REGRD;
            S_REGRD:  state_d = S_EXEC;
            S_EXEC:   state_d = (mem_r_en || mem_w_en) ? S_MEM : S_WBSEL;
            S_MEM: begin
                if (mem_ready) begin
                    state_d = S_WBSEL;
                end else if (mem_timeout) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WBSEL:  state_d = S_WB;
            S_WB:     state_d = S_PCUPD;
            S_PCUPD:  state_d = run ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Strobes are pure state decodes, except wb_en which also gates on reg_w_en
    always_comb begin
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        regrd_en  = 1'b0;
        exec_en   = 1'b0;
        mem_req   = 1'b0;
        wbsel_en  = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        case (state_q)
            S_FETCH:  fetch_en  = 1'b1;
            S_DECODE: decode_en = 1'b1;
            S_REGRD:  regrd_en  = 1'b1;
            S_EXEC:   exec_en   = 1'b1;
            S_MEM:    mem_req   = 1'b1;
            S_WBSEL:  wbsel_en  = 1'b1;
            S_WB:     wb_en     = reg_w_en;
            S_PCUPD:  pc_en     = 1'b1;
            S_IDLE:   busy      = 1'b0;
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: random instruction streams are modelled as
// expected state sequences and strobe counts, and a monitor checks each one as it retires.
module tb_cpu_sequencer;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;

    logic             clk;
    logic             reset;
    logic             run;
    logic             halt_op;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             reg_w_en;
    logic             mem_ready;
    logic             fetch_en;
    logic             decode_en;
    logic             regrd_en;
    logic             exec_en;
    logic             mem_req;
    logic             wbsel_en;
    logic             wb_en;
    logic             pc_en;
    logic [3:0]       state;
    logic             busy;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] retired;

    cpu_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .halt_op(halt_op),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .reg_w_en(reg_w_en),
        .mem_ready(mem_ready), .fetch_en(fetch_en), .decode_en(decode_en),
        .regrd_en(regrd_en), .exec_en(exec_en), .mem_req(mem_req),
        .wbsel_en(wbsel_en), .wb_en(wb_en), .pc_en(pc_en), .state(state),
        .busy(busy), .halted(halted), .mem_err(mem_err), .retired(retired)
    );

    // Instruction kinds: plain ALU, memory access completing after n waits,
    // halt opcode, and memory access that never gets mem_ready
    localparam int K_ALU = 0, K_MEM = 1, K_HALT = 2, K_TMO = 3;

    typedef struct {
        string       seq;
        logic [63:0] counts;
        bit          ends_halt;
        bit          err;
        int          retired_after;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   model_retired;
    int   ready_at;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic check_vec(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic check_str(input string name, input string actual, input string expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%s expected=%s", name, actual, expected);
        end
    endtask

    task automatic abort_run(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout expected=event", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic logic [7:0] strobes();
        return {fetch_en, decode_en, regrd_en, exec_en, mem_req, wbsel_en, wb_en, pc_en};
    endfunction

    // Drive one instruction's control inputs and push what the spec says it must produce
    task automatic apply_stimulus(input int kind, input int n, input bit regw, input bit store);
        exp_t e;
        int   mem_cycles;
        bit   completes;
        halt_op  = (kind == K_HALT);
        reg_w_en = regw;
        if (kind == K_ALU) begin
            mem_r_en = 1'b0;
            mem_w_en = 1'b0;
        end else begin
            mem_r_en = !store;
            mem_w_en = store;
        end
        ready_at   = (kind == K_MEM) ? n + 1 : 0;
        completes  = (kind == K_ALU) || (kind == K_MEM);
        mem_cycles = (kind == K_MEM) ? n + 1 : (kind == K_TMO) ? MEM_TIMEOUT + 1 : 0;
        e.seq = "01";
        if (kind != K_HALT) e.seq = {e.seq, "23"};
        for (int i = 0; i < mem_cycles; i++) e.seq = {e.seq, "4"};
        if (completes) e.seq = {e.seq, "567"};
        e.counts = {8'd1, 8'd1, 8'(kind != K_HALT), 8'(kind != K_HALT), 8'(mem_cycles),
                    8'(completes), 8'(completes && regw), 8'(completes)};
        e.ends_halt = !completes;
        e.err       = (kind == K_TMO);
        if (completes) model_retired = (model_retired + 1) % (1 << CNT_W);
        e.retired_after = model_retired;
        exp_q.push_back(e);
    endtask

    task automatic apply_random();
        int kind;
        kind = $urandom_range(0, 1);
        apply_stimulus(kind, $urandom_range(0, MEM_TIMEOUT), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
    endtask

    task automatic wait_end();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (pc_en || halted) return;
        end
        abort_run("wait_end");
    endtask

    task automatic check_quiet(input string name, input int exp_state);
        check_output({name, "_state"}, int'(state), exp_state);
        check_vec({name, "_outputs"}, {56'd0, strobes()}, 64'd0);
    endtask

    // Memory responder: raise mem_ready in the chosen MEM cycle
    initial begin
        int k;
        k = 0;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                k++;
                mem_ready = (k == ready_at);
            end else begin
                k = 0;
                mem_ready = 1'b0;
            end
        end
    end

    task automatic compare_record(input string seq, input logic [63:0] cnts, input bit ended_halt,
                                  output bit pend, output int pend_val);
        exp_t e;
        pend = 1'b0;
        pend_val = 0;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=record expected=none");
            return;
        end
        e = exp_q.pop_front();
        check_str("state_seq", seq, e.seq);
        check_vec("strobe_counts", cnts, e.counts);
        check_output("ends_in_halt", int'(ended_halt), int'(e.ends_halt));
        check_output("mem_err", int'(mem_err), int'(e.err));
        if (ended_halt) begin
            check_output("halt_retired", int'(retired), e.retired_after);
            check_output("halt_busy", int'(busy), 0);
            check_output("halt_state", int'(state), 9);
        end else begin
            pend = 1'b1;
            pend_val = e.retired_after;
        end
    endtask

    // Monitor: collect one instruction from FETCH to PCUPD or HALT, then score it
    initial begin
        bit    active;
        bit    pend;
        int    pend_val;
        string seq;
        int    c [8];
        active = 1'b0;
        pend = 1'b0;
        pend_val = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check_output("retired_after_pcupd", int'(retired), pend_val);
                    pend = 1'b0;
                end
                if (fetch_en && !active) begin
                    active = 1'b1;
                    seq = "";
                    foreach (c[i]) c[i] = 0;
                end
                if (active) begin
                    if (halted) begin
                        active = 1'b0;
                        compare_record(seq, {8'(c[0]), 8'(c[1]), 8'(c[2]), 8'(c[3]), 8'(c[4]),
                                             8'(c[5]), 8'(c[6]), 8'(c[7])}, 1'b1, pend, pend_val);
                    end else begin
                        seq = {seq, $sformatf("%0h", state)};
                        for (int i = 0; i < 8; i++) c[i] += int'(strobes()[7 - i]);
                        if (pc_en) begin
                            active = 1'b0;
                            compare_record(seq, {8'(c[0]), 8'(c[1]), 8'(c[2]), 8'(c[3]), 8'(c[4]),
                                                 8'(c[5]), 8'(c[6]), 8'(c[7])}, 1'b0, pend, pend_val);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int cnt;
        checks = 0;
        failures = 0;
        model_retired = 0;
        ready_at = 0;
        reset = 1'b1;
        run = 1'b1;
        halt_op = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        reg_w_en = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset", 8);
        check_output("reset_busy_halted_err", int'({busy, halted, mem_err}), 0);
        check_output("reset_retired", int'(retired), 0);

        // Random instruction streams, each ended by a halt opcode or a memory timeout
        for (int r = 0; r < 4; r++) begin
            model_retired = 0;
            exp_q.delete();
            if (r == 0) apply_stimulus(K_ALU, 0, 1'b1, 1'b0);
            else if (r == 1) apply_stimulus(K_MEM, 2, 1'b1, 1'b0);
            else apply_random();
            run = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            cnt = 5 + $urandom_range(0, 3);
            for (int i = 1; i <= cnt; i++) begin
                wait_end();
                if (i == cnt) apply_stimulus((r % 2 == 1) ? K_TMO : K_HALT, 0, 1'b1, 1'b1);
                else if (i == 1) apply_stimulus(K_MEM, MEM_TIMEOUT, 1'b1, 1'($urandom_range(0, 1)));
                else if (i == 2) apply_stimulus(K_MEM, 0, 1'b0, 1'b1);
                else apply_random();
            end
            wait_end();
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check_quiet("halt_hold", 9);
            end
            check_output("queue_drained", exp_q.size(), 0);
            reset = 1'b1;
            #1;
            check_quiet("reset_from_halt", 8);
            check_output("reset_from_halt_flags", int'({busy, halted, mem_err}), 0);
            check_output("reset_from_halt_retired", int'(retired), 0);
        end

        // run dropped during EXEC of the fifth instruction
        model_retired = 0;
        exp_q.delete();
        apply_stimulus(K_ALU, 0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                for (int k = 0; k < 20 && !exec_en; k++) @(negedge clk);
                if (!exec_en) abort_run("wait_exec");
                run = 1'b0;
            end
            wait_end();
            if (i < 5) apply_stimulus(K_ALU, 0, 1'($urandom_range(0, 1)), 1'b0);
        end
        @(negedge clk);
        check_output("idle_after_run_drop", int'(state), 8);
        check_output("retired_five", int'(retired), 5);
        @(negedge clk);
        check_quiet("idle_hold", 8);
        apply_stimulus(K_ALU, 0, 1'b1, 1'b0);
        run = 1'b1;
        @(negedge clk);
        check_output("fetch_after_run", int'(state), 0);

        // Asynchronous reset in WB must abort before any further edge
        for (int k = 0; k < 20 && state != 4'd6; k++) @(negedge clk);
        if (state != 4'd6) abort_run("wait_wb");
        check_output("wb_en_before_reset", int'(wb_en), 1);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_state", int'(state), 8);
        check_output("async_reset_wb_en", int'(wb_en), 0);
        check_output("async_reset_retired", int'(retired), 0);
        check_output("async_reset_busy", int'(busy), 0);
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_output("no_pc_en_after_reset", int'(pc_en), 0);
        end
        run = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_quiet("idle_after_release", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        abort_run("global_watchdog");
    end

endmodule
